// File: rtl/parity_pkg.sv
// ---------------------------------------------------------------------------
// parity_pkg
// Shared types and helpers for the parity stream arbiter and the
// parity generator/checker datapath.
//   DATA_W      : width of one data byte
//   ch_t        : channel index (0 or 1)
//   out_state_e : occupancy of the output register
//   parity_of() : generated parity bit for a byte (even or odd rule)
// ---------------------------------------------------------------------------
package parity_pkg;

  localparam int DATA_W = 8;

  typedef logic ch_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Parity bit that makes the total count of ones even (odd = 0)
  // or odd (odd = 1) across data plus the parity bit itself.
  function automatic logic parity_of(input logic [DATA_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/parity_core.sv
// ---------------------------------------------------------------------------
// parity_core
// Combinational parity generator/checker for one byte.
//   data_i      : byte to protect/check
//   parity_in_i : parity bit received alongside the byte
//   gen_o       : parity generated from data_i
//   err_o       : received parity disagrees with generated parity
// ---------------------------------------------------------------------------
module parity_core
  import parity_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              parity_in_i,
  output logic              gen_o,
  output logic              err_o
);

  always_comb begin
    gen_o = parity_of(data_i, PARITY_ODD);
    err_o = gen_o ^ parity_in_i;
  end

endmodule

// File: rtl/parity_stream_arb.sv
// ---------------------------------------------------------------------------
// parity_stream_arb
// Round-robin arbiter that feeds two byte sources through one shared parity
// checker into a single registered valid/ready output, with per-channel
// saturating parity-error counters.
//   clk, rst                 : clock, asynchronous active-high reset
//   sN_valid/data/parity     : channel N byte offer with its received parity
//   sN_ready                 : channel N byte accepted this cycle
//   m_valid/m_ready          : output handshake
//   m_data/parity/error/src  : checked byte, generated parity, mismatch, source
//   cnt_clr                  : synchronous clear of both error counters
//   err_cnt0/err_cnt1        : saturating parity-error counts per channel
// ---------------------------------------------------------------------------
module parity_stream_arb
  import parity_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0,
  parameter int CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_valid,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_parity,
  output logic              s0_ready,
  input  logic              s1_valid,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_parity,
  output logic              s1_ready,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_parity,
  output logic              m_error,
  output logic              m_src,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  err_cnt0,
  output logic [CNT_W-1:0]  err_cnt1
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  out_state_e        state_q, state_d;
  ch_t               last_q;
  ch_t               grant;
  logic              load;
  logic [DATA_W-1:0] selData;
  logic              selParity;
  logic              gen;
  logic              err;
  logic [DATA_W-1:0] data_q;
  logic              parity_q;
  logic              error_q;
  ch_t               src_q;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;

  // Round-robin grant: under contention the channel that did not win last
  // time goes; a lone requester always wins. A load happens whenever the
  // output register is free or being drained in this same edge.
  always_comb begin
    grant = 1'b0;
    if (s0_valid && s1_valid) begin
      grant = ~last_q;
    end else if (s1_valid) begin
      grant = 1'b1;
    end
    load      = ((state_q == OUT_EMPTY) || m_ready) && (s0_valid || s1_valid);
    selData   = grant ? s1_data : s0_data;
    selParity = grant ? s1_parity : s0_parity;
  end

  assign s0_ready = load && (grant == 1'b0);
  assign s1_ready = load && (grant == 1'b1);

  parity_core #(
    .PARITY_ODD (PARITY_ODD)
  ) u_core (
    .data_i      (selData),
    .parity_in_i (selParity),
    .gen_o       (gen),
    .err_o       (err)
  );

  // Output register occupancy: a load always leaves it FULL, otherwise a
  // drain with nothing to replace it empties it.
  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = OUT_FULL;
    end else if ((state_q == OUT_FULL) && m_ready) begin
      state_d = OUT_EMPTY;
    end
  end

  // Error counters: clear wins over an increment in the same cycle, and an
  // increment stops at the all-ones value.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (cnt_clr) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end else if (load && err) begin
      if ((grant == 1'b0) && (cnt0_q != CNT_MAX)) begin
        cnt0_d = cnt0_q + CNT_ONE;
      end
      if ((grant == 1'b1) && (cnt1_q != CNT_MAX)) begin
        cnt1_d = cnt1_q + CNT_ONE;
      end
    end
  end

  // State, output byte and counters. last_q resets to channel 1 so that
  // channel 0 wins the first contention after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= OUT_EMPTY;
      last_q   <= 1'b1;
      data_q   <= '0;
      parity_q <= 1'b0;
      error_q  <= 1'b0;
      src_q    <= 1'b0;
      cnt0_q   <= '0;
      cnt1_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      if (load) begin
        last_q   <= grant;
        data_q   <= selData;
        parity_q <= gen;
        error_q  <= err;
        src_q    <= grant;
      end
    end
  end

  assign m_valid  = (state_q == OUT_FULL);
  assign m_data   = data_q;
  assign m_parity = parity_q;
  assign m_error  = error_q;
  assign m_src    = src_q;
  assign err_cnt0 = cnt0_q;
  assign err_cnt1 = cnt1_q;

endmodule

// File: tb/tb_parity_stream_arb.sv
// ---------------------------------------------------------------------------
// tb_parity_stream_arb
// Directed scoreboard bench for parity_stream_arb (even parity, 2-bit
// counters so saturation is reachable). Each vector carries hand-computed
// generated parity and error flags for both channels; a monitor compares
// every presented output byte against the queued expectation.
// ---------------------------------------------------------------------------
module tb_parity_stream_arb;

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       err;
    logic       src;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       s0_valid, s1_valid;
  logic [7:0] s0_data, s1_data;
  logic       s0_parity, s1_parity;
  logic       s0_ready, s1_ready;
  logic       m_valid, m_ready;
  logic [7:0] m_data;
  logic       m_parity, m_error, m_src;
  logic       cnt_clr;
  logic [1:0] err_cnt0, err_cnt1;

  exp_t expQ[$];
  int   vecCount  = 0;
  int   missCount = 0;

  // Reference model of arbitration and counters
  logic mFull = 1'b0;
  logic mLast = 1'b1;
  int   mCnt0 = 0;
  int   mCnt1 = 0;

  parity_stream_arb #(
    .PARITY_ODD (1'b0),
    .CNT_W      (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .s0_valid  (s0_valid),
    .s0_data   (s0_data),
    .s0_parity (s0_parity),
    .s0_ready  (s0_ready),
    .s1_valid  (s1_valid),
    .s1_data   (s1_data),
    .s1_parity (s1_parity),
    .s1_ready  (s1_ready),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_parity  (m_parity),
    .m_error   (m_error),
    .m_src     (m_src),
    .cnt_clr   (cnt_clr),
    .err_cnt0  (err_cnt0),
    .err_cnt1  (err_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a rising edge; returns just after the next one.
  // gN/eN are the hand-computed generated parity and error for channel N.
  task automatic applyStimulus(
    input logic v0, input logic [7:0] d0, input logic p0, input logic g0, input logic e0,
    input logic v1, input logic [7:0] d1, input logic p1, input logic g1, input logic e1,
    input logic mr, input logic clr);
    logic g;
    logic ld;
    s0_valid = v0; s0_data = d0; s0_parity = p0;
    s1_valid = v1; s1_data = d1; s1_parity = p1;
    m_ready  = mr; cnt_clr = clr;
    @(negedge clk);
    g  = (v0 && v1) ? ~mLast : v1;
    ld = (!mFull || mr) && (v0 || v1);
    checkOutput("s0_ready", {7'b0, s0_ready}, {7'b0, ld && !g});
    checkOutput("s1_ready", {7'b0, s1_ready}, {7'b0, ld && g});
    checkOutput("m_valid", {7'b0, m_valid}, {7'b0, mFull});
    checkOutput("err_cnt0", {6'b0, err_cnt0}, 8'(mCnt0));
    checkOutput("err_cnt1", {6'b0, err_cnt1}, 8'(mCnt1));
    if (ld) begin
      expQ.push_back(g ? exp_t'{d1, g1, e1, 1'b1} : exp_t'{d0, g0, e0, 1'b0});
      mLast = g;
      mFull = 1'b1;
    end else if (mFull && mr) begin
      mFull = 1'b0;
    end
    if (clr) begin
      mCnt0 = 0;
      mCnt1 = 0;
    end else if (ld && (g ? e1 : e0)) begin
      if (!g && mCnt0 < 3) mCnt0++;
      if (g && mCnt1 < 3) mCnt1++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  // Monitor: the byte on m_* must match the oldest expectation every cycle
  // it is presented (so held bytes are checked for stability too), and is
  // retired when the downstream accepts it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && m_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_output", {7'b0, m_valid}, 8'h00);
        end else begin
          e = expQ[0];
          checkOutput("m_data", m_data, e.data);
          checkOutput("m_parity", {7'b0, m_parity}, {7'b0, e.par});
          checkOutput("m_error", {7'b0, m_error}, {7'b0, e.err});
          checkOutput("m_src", {7'b0, m_src}, {7'b0, e.src});
          if (m_ready) void'(expQ.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    s0_valid = 1'b0; s0_data = 8'h00; s0_parity = 1'b0;
    s1_valid = 1'b0; s1_data = 8'h00; s1_parity = 1'b0;
    m_ready = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state with both channels idle
    @(negedge clk);
    checkOutput("rst_m_valid", {7'b0, m_valid}, 8'h00);
    checkOutput("rst_m_data", m_data, 8'h00);
    checkOutput("rst_m_parity", {7'b0, m_parity}, 8'h00);
    checkOutput("rst_m_error", {7'b0, m_error}, 8'h00);
    checkOutput("rst_m_src", {7'b0, m_src}, 8'h00);
    checkOutput("rst_err_cnt0", {6'b0, err_cnt0}, 8'h00);
    checkOutput("rst_err_cnt1", {6'b0, err_cnt1}, 8'h00);
    @(posedge clk);
    #1;

    // Single byte A5 (four ones) with correct even parity 0
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);

    // Continuous contention: 01/p1 and 03/p0 are both correct
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    idle(1);

    // 07 has three ones: generated parity 1, received 0 -> error on ch1
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(1);

    // Backpressure: fill, hold 3 cycles, then drain and load in one edge
    applyStimulus(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1);

    // Five bad bytes on ch0 saturate the 2-bit counter at 3
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    // Clear wins over a simultaneous bad byte
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1);

    // Fill with a bad ch1 byte under contention, hold, then reset mid-transfer
    applyStimulus(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_m_valid", {7'b0, m_valid}, 8'h00);
    checkOutput("async_m_data", m_data, 8'h00);
    checkOutput("async_err_cnt0", {6'b0, err_cnt0}, 8'h00);
    checkOutput("async_err_cnt1", {6'b0, err_cnt1}, 8'h00);
    expQ.delete();
    mFull = 1'b0;
    mLast = 1'b1;
    mCnt0 = 0;
    mCnt1 = 0;
    @(posedge clk);
    #1 rst = 1'b0;

    // First contention after reset must go to ch0
    applyStimulus(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);

    checkOutput("queue_empty", 8'(expQ.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/parity_stream_arb.md
# parity_stream_arb

Two-channel arbiter and sequencer for the shared 8-bit parity generator/checker. Two byte sources, each carrying its own received parity bit, compete for the single parity datapath. The block grants them round-robin and registers one checked byte per cycle onto a valid/ready output. It also keeps per-channel saturating parity-error counters for status readout.

## Interface
- PARITY_ODD, 0, 0 = even parity (generated bit makes the total number of ones even); 1 = odd parity.
- CNT_W, 8, width of each error counter.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- s0_valid  in  1  channel 0 byte offered
- s0_data  in  8  channel 0 data byte
- s0_parity  in  1  channel 0 received parity bit
- s0_ready  out  1  channel 0 byte accepted this cycle
- s1_valid, s1_data, s1_parity, s1_ready  (same directions and widths as s0_*)  channel 1
- m_valid  out  1  output register holds a checked byte
- m_ready  in  1  downstream accepts
- m_data  out  8  byte passed through unchanged
- m_parity  out  1  parity generated from m_data
- m_error  out  1  received parity mismatched the generated parity
- m_src  out  1  channel that supplied the byte (0/1)
- cnt_clr  in  1  synchronous clear of both counters
- err_cnt0  out  CNT_W  channel 0 error count, saturating
- err_cnt1  out  CNT_W  channel 1 error count, saturating

## Operation
- Parity rule: gen = ^data ^ PARITY_ODD; err = gen ^ received parity.
- Output register states:
  - EMPTY: m_valid = 0.
  - FULL: m_valid = 1.
- Load condition: `load = (EMPTY | m_ready) & (s0_valid | s1_valid)`.
  - On load, the register takes the granted byte and goes to, or stays in, FULL.
  - FULL & m_ready & no request → EMPTY.
- Grant is round-robin.
  - `last` records the channel most recently granted.
  - When both channels are valid, the channel ≠ `last` wins.
  - When only one channel is valid, it wins.
  - `last` updates only on a load.
- sN_ready = load & (grant == N). This is combinational, at most one is high per cycle, and never high while FULL & !m_ready.
- Counters:
  - On a load with err = 1, the selected channel's counter increments.
  - A counter saturates at 2^CNT_W−1.
  - cnt_clr has priority over an increment in the same cycle; the counter reads 0 next cycle.
- Output stability: while FULL & !m_ready, m_data, m_parity, m_error and m_src hold stable.
- Reset (asynchronous, any time including mid-transfer):
  - m_valid = 0, m_data = 0, m_parity = 0, m_error = 0, m_src = 0.
  - err_cnt0 = err_cnt1 = 0.
  - `last` = 1, so channel 0 wins the first contention.
  - Any in-flight byte is dropped.

## Timing
- Latency: one cycle from the sN_valid & sN_ready edge to m_valid with that byte.
- Throughput: one byte per cycle when m_ready is held high. With both channels continuously valid, grants strictly alternate 0,1,0,1…
- Backpressure: if m_ready = 0 while FULL, both sN_ready are 0 and the sources must hold their data.
- Simultaneous drain and load in FULL: the old byte leaves and the new byte is registered in the same edge, with no bubble.
- Counter update is visible on err_cntN in the same cycle that the erroneous byte appears on m_*.
- Sources may drop sN_valid without a grant; the arbiter does not lock.

## Structure
- Package parity_pkg:
  - constant DATA_W = 8.
  - ch_t (1-bit channel index).
  - Function parity_of(data, odd) shared with the existing generator/checker.
- Sub-module parity_core: combinational; data, parity_in → gen, err. Instantiate it once, after the grant mux.
- Top level: grant logic, output register and state, two counters.

## Test plan
1. Reset with both channels idle → all outputs 0.
   - s0 offers 8'hA5 with parity 0 → next cycle m_valid = 1, m_data = A5, m_parity = 0, m_error = 0, m_src = 0.
2. Both valid continuously, m_ready = 1:
   - s0 = 8'h01/p1, s1 = 8'h03/p0.
   - Required: m_src alternates 0,1,0,1; no error; one byte per cycle.
3. s1 sends 8'h07 with parity 0 (correct parity is 1) → m_error = 1, m_parity = 1, err_cnt1 = 1, err_cnt0 unchanged.
4. m_ready = 0 for 3 cycles while FULL:
   - m_* stable, s0_ready = s1_ready = 0.
   - Then m_ready = 1 → the held byte drains and the next byte loads in the same cycle.
5. Counter limits:
   - With CNT_W = 2, send 5 bad bytes on ch0 → err_cnt0 saturates at 3.
   - cnt_clr asserted together with another bad byte → err_cnt0 = 0 next cycle.
6. Assert rst while FULL and mid-arbitration → m_valid = 0 immediately (asynchronous) and counters = 0. After release with both channels valid, the first grant goes to ch0.
